tdm_mux81: RTL and testbench

- Time-division 8:1 multiplexer and serializer; transmit-side counterpart to the 1:8 demultiplexer (`demux18`).
- Snapshots an 8-bit parallel word on `start`, then drives one bit at a time on `data` with the matching channel index on `control`.
- A downstream `demux18` driven by `data`/`control` reconstructs the word on its `outputs`.
- Used as the channel source in the W1 mux/demux loopback lab.

---
 rtl/tdm_mux81_pkg.sv | 15 +
 rtl/tdm_mux81_if.sv | 35 +++
 rtl/tdm_mux81_dwell_cnt.sv | 29 ++
 rtl/tdm_mux81.sv | 135 +++++++++++++
 tb/tb_tdm_mux81.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_mux81_pkg.sv
// tdm_pkg: shared types and constants for the tdm_mux81 serializer slice.
// Optional build macro used by the slice: TDM_MUX81_PARITY_EN.
package tdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NCH_DEF   = 8;
    localparam int CH_W      = 3;
    localparam int DWELL_DEF = 4;

endpackage

// File: rtl/tdm_mux81_if.sv
// tdm_mux81_if: request and serial-slot bundle between a channel source and tdm_mux81.
// parity_slot exists only when TDM_MUX81_PARITY_EN is defined.
interface tdm_mux81_if;
    import tdm_pkg::*;

    logic                start;
    logic                fixed_mode;
    logic [CH_W-1:0]     sel;
    logic [NCH_DEF-1:0]  inputs;
    logic                data;
    logic [CH_W-1:0]     control;
    logic                valid;
    logic                busy;
    logic                done;
`ifdef TDM_MUX81_PARITY_EN
    logic                parity_slot;
`endif

    modport master (
        output start, fixed_mode, sel, inputs,
        input  data, control, valid, busy, done
`ifdef TDM_MUX81_PARITY_EN
        , input parity_slot
`endif
    );

    modport slave (
        input  start, fixed_mode, sel, inputs,
        output data, control, valid, busy, done
`ifdef TDM_MUX81_PARITY_EN
        , output parity_slot
`endif
    );

endinterface

// File: rtl/tdm_mux81_dwell_cnt.sv
// tdm_dwell_cnt: counts 0..DWELL-1 while enabled; tc flags the last cycle of a slot.
module tdm_dwell_cnt #(
    parameter int DWELL = tdm_pkg::DWELL_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    // Clear has priority so a terminal count restarts the next slot at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/tdm_mux81.sv
// tdm_mux81: snapshots an 8-bit word on start and serializes it one channel per
// DWELL-cycle slot onto data/control (all outputs registered).
// Build macro TDM_MUX81_PARITY_EN adds an even-parity ninth slot in scan mode.
module tdm_mux81
    import tdm_pkg::*;
#(
    parameter int DWELL = DWELL_DEF,
    parameter int NCH   = NCH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_mux81_if.slave   bus
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH_DEF - 1);

    if (NCH != 8) begin : g_bad_nch
        $error("tdm_mux81: NCH must be 8");
    end
    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
        $error("tdm_mux81: DWELL must be 1..255");
    end

    state_t              state;
    logic                mode;
    logic                par_ph;
    logic [CH_W-1:0]     ch;
    logic [NCH_DEF-1:0]  snap;
    logic                tc;

    logic                data_p1;
    logic [CH_W-1:0]     control_p1;
    logic                valid_p1;
    logic                busy_p1;
    logic                done_p1;

    tdm_dwell_cnt #(.DWELL(DWELL)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state != SCAN) | tc),
        .en    (state == SCAN),
        .tc    (tc)
    );

    // Sequencer: snapshot on start, step channels on terminal count, registered slot outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode       <= 1'b0;
            par_ph     <= 1'b0;
            ch         <= '0;
            snap       <= '0;
            data_p1    <= 1'b0;
            control_p1 <= '0;
            valid_p1   <= 1'b0;
            busy_p1    <= 1'b0;
            done_p1    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_p1    <= 1'b0;
                    control_p1 <= '0;
                    valid_p1   <= 1'b0;
                    busy_p1    <= 1'b0;
                    done_p1    <= 1'b0;
                    par_ph     <= 1'b0;
                    if (bus.start) begin
                        snap  <= bus.inputs;
                        mode  <= bus.fixed_mode;
                        ch    <= bus.fixed_mode ? bus.sel : '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    valid_p1 <= 1'b1;
                    busy_p1  <= 1'b1;
                    done_p1  <= 1'b0;
                    if (par_ph) begin
                        data_p1    <= ^snap;
                        control_p1 <= '0;
                    end else begin
                        data_p1    <= snap[ch];
                        control_p1 <= ch;
                    end
                    if (tc) begin
                        if (mode || par_ph) begin
                            state <= DONE;
                        end else if (ch != LAST_CH) begin
                            ch <= ch + 1'b1;
                        end else begin
`ifdef TDM_MUX81_PARITY_EN
                            par_ph <= 1'b1;
`else
                            state  <= DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    data_p1    <= 1'b0;
                    control_p1 <= '0;
                    valid_p1   <= 1'b0;
                    busy_p1    <= 1'b0;
                    done_p1    <= 1'b1;
                    par_ph     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TDM_MUX81_PARITY_EN
    logic parity_p1;

    // Parity-slot flag tracks the registered slot outputs cycle for cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_p1 <= 1'b0;
        end else begin
            parity_p1 <= (state == SCAN) && par_ph;
        end
    end

    assign bus.parity_slot = parity_p1;
`endif

    assign bus.data    = data_p1;
    assign bus.control = control_p1;
    assign bus.valid   = valid_p1;
    assign bus.busy    = busy_p1;
    assign bus.done    = done_p1;

endmodule

// File: tb/tb_tdm_mux81.sv
// tb_tdm_mux81: directed bench for tdm_mux81 at DWELL=2 (parity slot when TDM_MUX81_PARITY_EN).
module tb_tdm_mux81;

    localparam int DW = 2;
`ifdef TDM_MUX81_PARITY_EN
    localparam int NS = 9;
`else
    localparam int NS = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    tdm_mux81_if bus ();

    tdm_mux81 #(.DWELL(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference demux18: only the addressed channel follows data while a slot is live.
    logic [7:0] dmx;
    always_comb begin
        dmx = 8'h00;
        if (bus.valid) dmx[bus.control] = bus.data;
    end

    // {parity_slot, data, control[2:0], valid, busy, done}
    function automatic logic [7:0] obs();
`ifdef TDM_MUX81_PARITY_EN
        return {bus.parity_slot, bus.data, bus.control, bus.valid, bus.busy, bus.done};
`else
        return {1'b0, bus.data, bus.control, bus.valid, bus.busy, bus.done};
`endif
    endfunction

    // Start edge k is the posedge inside this task; returns #1 after it.
    task automatic do_start(input logic [7:0] v, input logic fm, input logic [2:0] s, input logic hold);
        @(negedge clk);
        bus.inputs     = v;
        bus.fixed_mode = fm;
        bus.sel        = s;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", obs(), 8'h00);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle got=%b exp=%b", obs(), 8'h00);
        end
    endtask

    // Full scan; poke=1 re-pulses start and changes inputs mid-transfer.
    task automatic test_scan(input logic [7:0] v, input string tag, input logic poke);
        logic [7:0] e;
        logic [2:0] ch;
        do_start(v, 1'b0, 3'd5, 1'b0);
        for (int n = 1; n <= DW*NS + 3; n++) begin
            @(posedge clk); #1;
            ch = 3'((n - 1) / DW);
            if (n <= DW*8)            e = {1'b0, v[ch], ch, 3'b110};
            else if (n <= DW*NS)      e = {1'b1, ^v, 3'b000, 3'b110};
            else if (n == DW*NS + 1)  e = 8'h01;
            else                      e = 8'h00;
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL %s n=%0d got=%b exp=%b", tag, n, obs(), e);
            end
            if (poke && n == 5) begin
                bus.start  = 1'b1;
                bus.inputs = 8'hFF;
            end
            if (poke && n == 6) bus.start = 1'b0;
        end
        bus.inputs = 8'h00;
    endtask

    task automatic test_loopback();
        logic [7:0] e;
        int ch;
        do_start(8'h5C, 1'b0, 3'd0, 1'b0);
        for (int n = 1; n <= DW*8; n++) begin
            @(posedge clk); #1;
            ch = (n - 1) / DW;
            e  = 8'h5C & (8'h01 << ch);
            checks++;
            if (dmx !== e || bus.control !== 3'(ch)) begin
                errors++;
                $display("FAIL loopback n=%0d got=%b ctl=%0d exp=%b ctl=%0d", n, dmx, bus.control, e, ch);
            end
        end
        repeat (DW*(NS-8) + 2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL loopback_end got=%b exp=%b", obs(), 8'h00);
        end
    endtask

    task automatic test_fixed();
        logic [7:0] e;
        do_start(8'h20, 1'b1, 3'd5, 1'b0);
        for (int n = 1; n <= DW + 2; n++) begin
            @(posedge clk); #1;
            if (n <= DW)           e = {1'b0, 1'b1, 3'd5, 3'b110};
            else if (n == DW + 1)  e = 8'h01;
            else                   e = 8'h00;
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL fixed n=%0d got=%b exp=%b", n, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_start(8'hA6, 1'b0, 3'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (obs() !== {1'b0, 1'b0, 3'd3, 3'b110}) begin
            errors++;
            $display("FAIL rst_mid_slot3 got=%b exp=%b", obs(), {1'b0, 1'b0, 3'd3, 3'b110});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_async got=%b exp=%b", obs(), 8'h00);
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++;
            if (obs() !== 8'h00) begin
                errors++;
                $display("FAIL rst_mid_held n=%0d got=%b exp=%b", n, obs(), 8'h00);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            checks++;
            if (obs() !== 8'h00) begin
                errors++;
                $display("FAIL rst_mid_nodone n=%0d got=%b exp=%b", n, obs(), 8'h00);
            end
        end
        test_scan(8'hA6, "rst_mid_rescan", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic [2:0] ch;
        do_start(8'hA6, 1'b0, 3'd0, 1'b1);
        for (int n = 1; n <= DW*NS + 3; n++) begin
            @(posedge clk); #1;
            ch = 3'((n - 1) / DW);
            if (n <= DW*8)            e = {1'b0, bus.inputs[ch] & 1'b0 | 8'hA6 >> ch & 1'b1, ch, 3'b110};
            else if (n <= DW*NS)      e = {1'b1, 1'b0, 3'b000, 3'b110};
            else if (n == DW*NS + 1)  e = 8'h01;
            else if (n == DW*NS + 2)  e = 8'h00;
            else                      e = {1'b0, 1'b1, 3'd0, 3'b110};
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL b2b n=%0d got=%b exp=%b", n, obs(), e);
            end
            if (n == DW*NS + 1) bus.inputs = 8'h01;
            if (n == DW*NS + 2) bus.start  = 1'b0;
        end
        repeat (DW*NS + 2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL b2b_end got=%b exp=%b", obs(), 8'h00);
        end
        bus.inputs = 8'h00;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.fixed_mode = 1'b0;
        bus.sel        = 3'd0;
        bus.inputs     = 8'h00;
        test_reset();
        test_scan(8'hA6, "scan_a6", 1'b0);
        test_loopback();
        test_fixed();
        test_scan(8'hA6, "mid_start", 1'b1);
        test_reset_mid();
        test_back_to_back();
`ifdef TDM_MUX81_PARITY_EN
        test_scan(8'hA7, "parity_a7", 1'b0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
